// File: rtl/lpf_rdr_pkg.sv
// Shared definitions for the low-pass filter output-buffer reader.
package lpf_rdr_pkg;

    localparam int unsigned PIXEL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rdr_state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned x_w(input int unsigned line_length);
        return cnt_w(line_length);
    endfunction

    function automatic int unsigned y_w(input int unsigned line_count);
        return cnt_w(line_count);
    endfunction

endpackage

// File: rtl/lpf_skid_buf.sv
// Two-entry skid buffer holding words returned by the output FIFO.
module lpf_skid_buf
    import lpf_rdr_pkg::*;
#(
    parameter int unsigned W = PIXEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage, pointers and occupancy; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= 2'(occ + 2'(push) - 2'(pop));
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/lpf_obuf_reader.sv
// Drains the filter output FIFO into a valid/ready RGB565 pixel stream with
// frame/line markers. Optional frame counter port under LPF_RDR_FRAME_CNT_EN.
module lpf_obuf_reader
    import lpf_rdr_pkg::*;
#(
    parameter int unsigned LINE_LENGTH    = 480,
    parameter int unsigned LINE_COUNT     = 480,
    parameter int unsigned OBUF_PTR_WIDTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_enable,
    input  logic                      i_flush,
    output logic                      o_obuf_rd,
    input  logic [PIXEL_W-1:0]        i_obuf_data,
    input  logic                      i_obuf_empty,
    input  logic                      i_obuf_almostempty,
    input  logic [OBUF_PTR_WIDTH:0]   i_obuf_fill,
    output logic [PIXEL_W-1:0]        o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_sof,
    output logic                      o_eol,
    output logic                      o_eof,
    output logic                      o_busy,
    output logic                      o_error
`ifdef LPF_RDR_FRAME_CNT_EN
   ,output logic [15:0]               o_frame_cnt
`endif
);

    localparam int unsigned X_W = x_w(LINE_LENGTH);
    localparam int unsigned Y_W = y_w(LINE_COUNT);

    rdr_state_e     state;
    rdr_state_e     state_nxt;
    logic           inflight;
    logic [1:0]     occ;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           pop;
    logic           push;
    logic           x_last;
    logic           y_last;
    logic [2:0]     rd_budget;

    // Buffer for returned words; a word landing during flush is dropped.
    lpf_skid_buf #(
        .W (PIXEL_W)
    ) u_skid (
        .clk       (i_clk),
        .rst_n     (i_rstn),
        .flush     (i_flush),
        .push      (push),
        .push_data (i_obuf_data),
        .pop       (pop),
        .head      (o_data),
        .occ       (occ)
    );

    assign o_valid = (occ != 2'd0);
    assign pop     = o_valid && i_ready && !i_flush;
    assign push    = inflight && !i_flush;

    assign x_last = (x == X_W'(LINE_LENGTH - 1));
    assign y_last = (y == Y_W'(LINE_COUNT - 1));

    assign o_sof  = o_valid && (x == '0) && (y == '0);
    assign o_eol  = o_valid && x_last;
    assign o_eof  = o_eol && y_last;
    assign o_busy = o_valid || inflight;

    // Read issue: keep held plus in-flight words within the two buffer slots.
    always_comb begin
        rd_budget = 3'(occ) + 3'(inflight) - 3'(o_valid && i_ready);
        o_obuf_rd = (state == RUN) && !i_flush && !i_obuf_empty && (rd_budget < 3'd2);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_enable) state_nxt = RUN;
                RUN:     if (!i_enable) state_nxt = DRAIN;
                DRAIN: begin
                    if (i_enable) begin
                        state_nxt = RUN;
                    end else if ((occ == 2'd0) && !inflight) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FIFO read latency tracker: data is valid the cycle after a read.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            inflight <= 1'b0;
        end else begin
            inflight <= o_obuf_rd;
        end
    end

    // Pixel position counters, advanced on each accepted beat.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x <= '0;
            y <= '0;
        end else if (i_flush) begin
            x <= '0;
            y <= '0;
        end else if (pop) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : Y_W'(y + Y_W'(1));
            end else begin
                x <= X_W'(x + X_W'(1));
            end
        end
    end

    // Sticky error on inconsistent FIFO status flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_error <= 1'b0;
        end else if (i_flush) begin
            o_error <= 1'b0;
        end else if (i_obuf_empty && (!i_obuf_almostempty || (i_obuf_fill != '0))) begin
            o_error <= 1'b1;
        end
    end

`ifdef LPF_RDR_FRAME_CNT_EN
    // Completed-frame counter, wrapping at 16 bits.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_frame_cnt <= 16'd0;
        end else if (i_flush) begin
            o_frame_cnt <= 16'd0;
        end else if (pop && o_eof) begin
            o_frame_cnt <= 16'(o_frame_cnt + 16'd1);
        end
    end
`endif

endmodule

// File: tb/tb_lpf_obuf_reader.sv
// Testbench for lpf_obuf_reader with a queue-based FIFO model and scoreboard.
module tb_lpf_obuf_reader;

    localparam int LL = 4;
    localparam int LC = 2;
    localparam int PW = 4;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_obuf_rd;
    logic [15:0] i_obuf_data = 16'h0;
    logic        i_obuf_empty;
    logic        i_obuf_almostempty;
    logic [PW:0] i_obuf_fill;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        o_sof;
    logic        o_eol;
    logic        o_eof;
    logic        o_busy;
    logic        o_error;
`ifdef LPF_RDR_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    lpf_obuf_reader #(
        .LINE_LENGTH    (LL),
        .LINE_COUNT     (LC),
        .OBUF_PTR_WIDTH (PW)
    ) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_enable           (i_enable),
        .i_flush            (i_flush),
        .o_obuf_rd          (o_obuf_rd),
        .i_obuf_data        (i_obuf_data),
        .i_obuf_empty       (i_obuf_empty),
        .i_obuf_almostempty (i_obuf_almostempty),
        .i_obuf_fill        (i_obuf_fill),
        .o_data             (o_data),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_sof              (o_sof),
        .o_eol              (o_eol),
        .o_eof              (o_eof),
        .o_busy             (o_busy),
        .o_error            (o_error)
`ifdef LPF_RDR_FRAME_CNT_EN
       ,.o_frame_cnt        (o_frame_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Behavioural source FIFO: read data appears one cycle after a read.
    logic [15:0] fifo_mem [0:1023];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          err_mode = 0;
    logic [PW:0] fill_m;

    assign fill_m             = 5'(wr_idx - rd_idx);
    assign i_obuf_empty       = (err_mode != 0) ? 1'b1 : (fill_m == 5'd0);
    assign i_obuf_almostempty = (err_mode == 1) ? 1'b1 : (err_mode == 2) ? 1'b0 : (fill_m <= 5'd1);
    assign i_obuf_fill        = (err_mode == 1) ? 5'd3 : (err_mode == 2) ? 5'd0 : fill_m;

    always @(posedge i_clk) begin
        if (o_obuf_rd) begin
            i_obuf_data <= fifo_mem[rd_idx % 1024];
            rd_idx      <= rd_idx + 1;
        end
    end

    // Scoreboard state
    logic [15:0] exp_q [$];
    int   beat_k = 0;
    int   frames_m = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rd_cnt = 0;
    int   beats = 0;
    logic last_rd = 1'b0;
    logic last_valid = 1'b0;
    logic last_busy = 1'b0;
    logic last_hs = 1'b0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;

    logic rd_h [16];
    logic v_h [16];
    int   first_rd, first_v, run_rd, run_v, tot_rd, tot_v;
    int   rd0, b0;
    logic prev_hs, done_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_mem[wr_idx % 1024] = w;
        wr_idx++;
        exp_q.push_back(w);
    endtask

    // Per-cycle observation at the falling edge.
    task automatic mon();
        int pos;
        logic [15:0] e;
        last_rd    = o_obuf_rd;
        last_valid = o_valid;
        last_busy  = o_busy;
        last_hs    = 1'b0;
        if (o_obuf_rd) rd_cnt++;
        if (prev_stall) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_data", 32'(o_data), 32'(prev_data));
        end
        if (!o_valid) check("marker_qual", 32'({o_sof, o_eol, o_eof}), 32'd0);
        if (o_valid && i_ready && !i_flush) begin
            last_hs = 1'b1;
            beats++;
            check("spurious_beat", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                pos = beat_k % (LL * LC);
                check("data", 32'(o_data), 32'(e));
                check("sof", 32'(o_sof), 32'(pos == 0));
                check("eol", 32'(o_eol), 32'((pos % LL) == LL - 1));
                check("eof", 32'(o_eof), 32'(pos == LL * LC - 1));
                if (pos == LL * LC - 1) frames_m++;
                beat_k++;
            end
        end
        prev_stall = o_valid && !i_ready && !i_flush;
        prev_data  = o_data;
    endtask

    task automatic cyc();
        @(negedge i_clk);
        mon();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < budget) begin
            cyc();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        exp_q.delete();
        beat_k   = 0;
        frames_m = 0;
        cyc();
        i_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge i_clk);
        check("rst_rd", 32'(o_obuf_rd), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_sof", 32'(o_sof), 32'd0);
        check("rst_eol", 32'(o_eol), 32'd0);
        check("rst_eof", 32'(o_eof), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        cyc();

        // A: 8-word stream at full rate
        i_ready = 1'b1;
        for (int w = 1; w <= 8; w++) push_word(16'(w));
        cyc();
        cyc();
        check("A_idle_no_rd", 32'(rd_cnt), 32'd0);
        i_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            rd_h[i] = last_rd;
            v_h[i]  = last_valid;
        end
        first_rd = -1; first_v = -1; tot_rd = 0; tot_v = 0; run_rd = 0; run_v = 0;
        for (int i = 0; i < 16; i++) begin
            if (rd_h[i]) begin tot_rd++; if (first_rd < 0) first_rd = i; end
            if (v_h[i])  begin tot_v++;  if (first_v < 0)  first_v = i;  end
        end
        if (first_rd >= 0) for (int j = first_rd; j < 16 && rd_h[j]; j++) run_rd++;
        if (first_v >= 0)  for (int j = first_v; j < 16 && v_h[j]; j++) run_v++;
        check("A_first_rd", 32'(first_rd), 32'd1);
        check("A_rd_run", 32'(run_rd), 32'd8);
        check("A_rd_total", 32'(tot_rd), 32'd8);
        check("A_valid_latency", 32'(first_v - first_rd), 32'd2);
        check("A_valid_run", 32'(run_v), 32'd8);
        check("A_valid_total", 32'(tot_v), 32'd8);
        check("A_all_out", 32'(exp_q.size()), 32'd0);

        // B: backpressure mid-stream
        for (int w = 1; w <= 8; w++) push_word(16'(w));
        for (int i = 0; i < 4; i++) cyc();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("B_stall_rd", 32'(last_rd), 32'd0);
        end
        check("B_occ_full", 32'(dut.u_skid.occ), 32'd2);
        check("B_valid_held", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        drain("B_drain", 40);

        // C: single word then empty
        rd0 = rd_cnt; b0 = beats;
        push_word(16'hF800);
        prev_hs = 1'b0; done_c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (prev_hs && !done_c) begin
                check("C_busy_after_hs", 32'(last_busy), 32'd0);
                done_c = 1'b1;
            end
            prev_hs = last_hs;
        end
        check("C_busy_checked", 32'(done_c), 32'd1);
        check("C_one_rd", 32'(rd_cnt - rd0), 32'd1);
        check("C_one_beat", 32'(beats - b0), 32'd1);

        // D: flush the cycle after a read with one word held
        i_ready = 1'b0;
        push_word(16'hAAAA);
        push_word(16'h5555);
        cyc();
        cyc();
        do_flush();
        check("D_valid_after_flush", 32'(o_valid), 32'd0);
        check("D_busy_after_flush", 32'(o_busy), 32'd0);
        check("D_both_read", 32'(fill_m), 32'd0);
        i_ready = 1'b1;
        push_word(16'h1234);
        drain("D_drain", 20);

        // E: enable dropped with words held and in flight
        rd0 = rd_cnt; b0 = beats;
        for (int w = 1; w <= 4; w++) push_word(16'(16'h0E00 + w));
        cyc();
        cyc();
        i_enable = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        check("E_rd_count", 32'(rd_cnt - rd0), 32'd3);
        check("E_beats", 32'(beats - b0), 32'd3);
        check("E_left_in_fifo", 32'(exp_q.size()), 32'd1);
        check("E_idle_busy", 32'(o_busy), 32'd0);
        check("E_idle_valid", 32'(o_valid), 32'd0);
        i_enable = 1'b1;
        drain("E_drain", 20);

        // F: status error set, sticky, cleared by flush
        check("F_no_error", 32'(o_error), 32'd0);
        err_mode = 1;
        cyc();
        check("F_err_fill", 32'(o_error), 32'd1);
        err_mode = 0;
        for (int i = 0; i < 3; i++) cyc();
        check("F_err_sticky", 32'(o_error), 32'd1);
        do_flush();
        check("F_err_cleared", 32'(o_error), 32'd0);
        err_mode = 2;
        cyc();
        check("F_err_almost", 32'(o_error), 32'd1);
        err_mode = 0;
        do_flush();
        check("F_err_cleared2", 32'(o_error), 32'd0);

        // G: randomized traffic, backpressure and enable toggling
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 60 && fill_m < 5'd14) push_word(16'($urandom));
            i_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 5) i_enable = ~i_enable;
            cyc();
        end
        i_enable = 1'b1;
        i_ready  = 1'b1;
        drain("G_drain", 200);
`ifdef LPF_RDR_FRAME_CNT_EN
        check("G_frame_cnt", 32'(o_frame_cnt), 32'(16'(frames_m)));
`endif

        // H: two full frames after a flush
        do_flush();
        for (int w = 0; w < 2 * LL * LC; w++) push_word(16'($urandom));
        drain("H_drain", 60);
        check("H_frames_model", 32'(frames_m), 32'd2);
`ifdef LPF_RDR_FRAME_CNT_EN
        check("H_frame_cnt", 32'(o_frame_cnt), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
